// File: rtl/instruction_fetch_stage_pkg.sv
// Shared RISC-V fetch constants: logic levels, the NOP filler, FSM encoding
// and the output-buffer payload layout.
package instruction_fetch_stage_pkg;

    localparam logic            HIGH  = 1'b1;
    localparam logic            LOW   = 1'b0;
    localparam logic [31:0]     NOP   = 32'h0000_0013;

    localparam int unsigned     XLEN  = 32;
    localparam int unsigned     DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_stage_fifo.sv
// Two-entry FIFO with synchronous flush; head is read straight from storage.
module instruction_fetch_stage_fifo
    import instruction_fetch_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'(DEPTH)) || do_pop);

    always_ff @(posedge CLK) begin
        if (RST || flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: credit-limited instruction memory requests, in-flight PC
// tracking, response discard after redirects, and a 2-deep output buffer.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic [XLEN-1:0] PC,
    input  logic            PC_VALID,
    input  logic            CLEAR_INSTRUCTION_FETCH_STAGE,
    input  logic            STALL_INSTRUCTION_FETCH_STAGE,
    output logic [XLEN-1:0] IMEM_ADDR,
    output logic            IMEM_REQ,
    input  logic            IMEM_READY,
    input  logic [XLEN-1:0] IMEM_RDATA,
    input  logic            IMEM_RVALID,
    output logic [XLEN-1:0] INSTRUCTION,
    output logic [XLEN-1:0] PC_INSTRUCTION,
    output logic            INSTRUCTION_VALID,
    output logic            STALL_PROGRAME_COUNTER_STAGE
);

    fetch_state_e    state_q;
    logic [1:0]      discard_q;
    logic [1:0]      discard_d;
    logic [1:0]      ifq_count;
    logic [1:0]      obuf_count;
    logic [XLEN-1:0] ifq_head;
    fetch_entry_t    obuf_head;
    fetch_entry_t    obuf_wdata;
    logic            credit_ok;
    logic            accept;
    logic            rsp_live;
    logic            obuf_push;
    logic            obuf_pop;
    logic            out_valid;
    logic            clear;

    assign clear     = CLEAR_INSTRUCTION_FETCH_STAGE;
    // Credit counts only registered occupancy; a same-cycle pop frees nothing.
    assign credit_ok = (3'(ifq_count) + 3'(obuf_count)) < 3'(DEPTH);
    assign IMEM_REQ  = ((state_q == RUN) && (PC_VALID == HIGH) && (clear == LOW) && credit_ok)
                       ? HIGH : LOW;
    assign IMEM_ADDR = PC;
    assign accept    = IMEM_REQ && IMEM_READY;
    assign STALL_PROGRAME_COUNTER_STAGE = (clear == HIGH) ? LOW : ~accept;

    // Responses with nothing in flight are ignored entirely.
    assign rsp_live   = IMEM_RVALID && (ifq_count != 2'd0);
    assign obuf_push  = rsp_live && (discard_q == 2'd0) && !clear;
    assign out_valid  = (obuf_count != 2'd0);
    assign obuf_pop   = out_valid && !STALL_INSTRUCTION_FETCH_STAGE && !clear;
    assign obuf_wdata = '{instr: IMEM_RDATA, pc: ifq_head};

    always_comb begin
        discard_d = discard_q;
        if (clear) begin
            discard_d = ifq_count - 2'(rsp_live);
        end else if (rsp_live && (discard_q != 2'd0)) begin
            discard_d = discard_q - 2'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            discard_q <= 2'd0;
        end else begin
            discard_q <= discard_d;
            case (state_q)
                IDLE:    if (PC_VALID) state_q <= RUN;
                RUN:     if (clear && (discard_d != 2'd0)) state_q <= DRAIN;
                DRAIN:   if (discard_d == 2'd0) state_q <= RUN;
                default: state_q <= IDLE;
            endcase
        end
    end

    instruction_fetch_stage_fifo #(.WIDTH(XLEN)) u_inflight_q (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (accept),
        .data_i  (PC),
        .pop_i   (rsp_live),
        .flush_i (LOW),
        .head_o  (ifq_head),
        .count_o (ifq_count)
    );

    instruction_fetch_stage_fifo #(.WIDTH($bits(fetch_entry_t))) u_out_buf (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (obuf_push),
        .data_i  (obuf_wdata),
        .pop_i   (obuf_pop),
        .flush_i (clear),
        .head_o  (obuf_head),
        .count_o (obuf_count)
    );

    assign INSTRUCTION_VALID = out_valid;
    assign INSTRUCTION       = out_valid ? obuf_head.instr : NOP;
    assign PC_INSTRUCTION    = out_valid ? obuf_head.pc : '0;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: a queue-based model predicts
// requests and the output stream; a negedge monitor compares the DUT.
module tb_instruction_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] PC;
    logic        PC_VALID;
    logic        CLEAR;
    logic        STALL;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_REQ;
    logic        IMEM_READY;
    logic [31:0] IMEM_RDATA;
    logic        IMEM_RVALID;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC_INSTRUCTION;
    logic        INSTRUCTION_VALID;
    logic        STALL_PC;

    always #5 CLK = ~CLK;

    instruction_fetch_stage dut (
        .CLK                           (CLK),
        .RST                           (RST),
        .PC                            (PC),
        .PC_VALID                      (PC_VALID),
        .CLEAR_INSTRUCTION_FETCH_STAGE (CLEAR),
        .STALL_INSTRUCTION_FETCH_STAGE (STALL),
        .IMEM_ADDR                     (IMEM_ADDR),
        .IMEM_REQ                      (IMEM_REQ),
        .IMEM_READY                    (IMEM_READY),
        .IMEM_RDATA                    (IMEM_RDATA),
        .IMEM_RVALID                   (IMEM_RVALID),
        .INSTRUCTION                   (INSTRUCTION),
        .PC_INSTRUCTION                (PC_INSTRUCTION),
        .INSTRUCTION_VALID             (INSTRUCTION_VALID),
        .STALL_PROGRAME_COUNTER_STAGE  (STALL_PC)
    );

    // Reference model: requests outstanding at the memory, and the expected
    // instruction stream (the scoreboard queue) waiting for the decoder.
    typedef struct { logic [31:0] pc; bit drop; } inflight_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } outent_t;

    inflight_t m_inflight[$];
    outent_t   m_obuf[$];
    bit        m_running;
    bit        m_init = 1'b0;
    bit        m_last_accept;
    bit        m_last_clear;
    int        n_cmp = 0;
    int        n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_draining();
        foreach (m_inflight[i]) if (m_inflight[i].drop) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_req();
        return m_running && !m_draining() && (PC_VALID === 1'b1) && (CLEAR !== 1'b1)
               && ((m_inflight.size() + m_obuf.size()) < 2);
    endfunction

    // Model update at each rising edge from the inputs driven for that cycle.
    always @(posedge CLK) begin
        bit        acc;
        inflight_t e;
        if (RST) begin
            m_inflight.delete();
            m_obuf.delete();
            m_running     = 1'b0;
            m_init        = 1'b1;
            m_last_accept = 1'b0;
            m_last_clear  = 1'b0;
        end else begin
            acc = m_req() && IMEM_READY;
            if (m_obuf.size() != 0 && !STALL && !CLEAR) void'(m_obuf.pop_front());
            if (IMEM_RVALID && m_inflight.size() != 0) begin
                e = m_inflight.pop_front();
                if (!e.drop && !CLEAR) m_obuf.push_back('{IMEM_RDATA, e.pc});
            end
            if (CLEAR) begin
                m_obuf.delete();
                foreach (m_inflight[i]) m_inflight[i].drop = 1'b1;
            end
            if (acc) m_inflight.push_back('{PC, 1'b0});
            if (!m_running && PC_VALID) m_running = 1'b1;
            m_last_accept = acc;
            m_last_clear  = CLEAR;
        end
    end

    // Monitor: compare every DUT output against the model mid-cycle.
    always @(negedge CLK) begin
        bit exp_req;
        if (m_init) begin
            exp_req = m_req();
            check("imem_req", 64'(IMEM_REQ), 64'(exp_req));
            check("imem_addr", 64'(IMEM_ADDR), 64'(PC));
            check("stall_pc", 64'(STALL_PC), CLEAR ? 64'd0 : 64'(!(exp_req && IMEM_READY)));
            check("instr_valid", 64'(INSTRUCTION_VALID), 64'(m_obuf.size() != 0));
            if (m_obuf.size() != 0) begin
                check("instruction", 64'(INSTRUCTION), 64'(m_obuf[0].instr));
                check("pc_instruction", 64'(PC_INSTRUCTION), 64'(m_obuf[0].pc));
            end else begin
                check("instruction_nop", 64'(INSTRUCTION), 64'h13);
                check("pc_instruction_zero", 64'(PC_INSTRUCTION), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; CLEAR = 1'b0; STALL = 1'b0; IMEM_RVALID = 1'b0;
        PC_VALID = 1'b0; IMEM_READY = 1'b0; IMEM_RDATA = '0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // One cycle of a cooperative memory and PC stage.
    task automatic step(input bit auto_rsp);
        IMEM_RVALID = auto_rsp && (m_inflight.size() != 0);
        IMEM_RDATA  = $urandom;
        tick();
        if (m_last_accept) PC = PC + 32'd4;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  acc_seen;
        bit  seen;
        RST = 1'b1; PC = '0; PC_VALID = 1'b0; CLEAR = 1'b0; STALL = 1'b0;
        IMEM_READY = 1'b0; IMEM_RDATA = '0; IMEM_RVALID = 1'b0;

        // Reset state and first fetch latency.
        do_reset();
        #1;
        check("rst_valid", 64'(INSTRUCTION_VALID), 64'd0);
        check("rst_instr", 64'(INSTRUCTION), 64'h13);
        check("rst_pc_instr", 64'(PC_INSTRUCTION), 64'd0);
        check("rst_req", 64'(IMEM_REQ), 64'd0);
        check("rst_stall_pc", 64'(STALL_PC), 64'd1);
        PC = 32'h0; PC_VALID = 1'b1; IMEM_READY = 1'b1; STALL = 1'b1;
        tick();
        #1 check("first_req", 64'(IMEM_REQ), 64'd1);
        tick();
        PC_VALID = 1'b0; PC = 32'h4;
        IMEM_RVALID = 1'b1; IMEM_RDATA = 32'h0050_0093;
        tick();
        IMEM_RVALID = 1'b0;
        #1;
        check("first_valid", 64'(INSTRUCTION_VALID), 64'd1);
        check("first_instr", 64'(INSTRUCTION), 64'h0050_0093);
        check("first_pc", 64'(PC_INSTRUCTION), 64'd0);
        STALL = 1'b0;
        tick();

        // Decode stall with a streaming PC: credit caps accepts at two.
        do_reset();
        PC = 32'h0; PC_VALID = 1'b1; IMEM_READY = 1'b1; STALL = 1'b1;
        acc_seen = 0;
        for (int i = 0; i < 8; i++) begin
            #1 if (IMEM_REQ && IMEM_READY) acc_seen++;
            step(1'b1);
        end
        #1;
        check("stall_accepts", 64'(acc_seen), 64'd2);
        check("stall_pc_held", 64'(STALL_PC), 64'd1);
        check("stall_head_pc", 64'(PC_INSTRUCTION), 64'h0);
        STALL = 1'b0;
        step(1'b1);
        check("release_head_pc", 64'(PC_INSTRUCTION), 64'h4);
        for (int i = 0; i < 6; i++) step(1'b1);

        // Reset with a full output buffer.
        STALL = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1);
        RST = 1'b1; IMEM_RVALID = 1'b0;
        tick();
        check("rst_full_valid", 64'(INSTRUCTION_VALID), 64'd0);
        check("rst_full_instr", 64'(INSTRUCTION), 64'h13);
        check("rst_full_req", 64'(IMEM_REQ), 64'd0);
        RST = 1'b0; STALL = 1'b0;

        // Redirect with two requests in flight.
        do_reset();
        PC = 32'h8; PC_VALID = 1'b1; IMEM_READY = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0);
        CLEAR = 1'b1; PC = 32'h40;
        #1;
        check("clear_stall_pc", 64'(STALL_PC), 64'd0);
        check("clear_no_req", 64'(IMEM_REQ), 64'd0);
        tick();
        CLEAR = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1'b1);
            if (INSTRUCTION_VALID) begin
                seen = 1'b1;
                check("redirect_pc", 64'(PC_INSTRUCTION), 64'h40);
            end
        end
        if (!seen) check("redirect_timeout", 64'd0, 64'd1);

        // Redirect coincident with the first response.
        do_reset();
        PC = 32'h8; PC_VALID = 1'b1; IMEM_READY = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0);
        CLEAR = 1'b1; IMEM_RVALID = 1'b1; PC = 32'h40;
        tick();
        CLEAR = 1'b0; IMEM_RVALID = 1'b1;
        tick();
        IMEM_RVALID = 1'b0;
        #1 check("drain_exit_req", 64'(IMEM_REQ), 64'd1);
        for (int i = 0; i < 6; i++) step(1'b1);

        // Memory not ready: request and address held.
        do_reset();
        PC = 32'h100; PC_VALID = 1'b1; IMEM_READY = 1'b0;
        step(1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("notready_req", 64'(IMEM_REQ), 64'd1);
            check("notready_addr", 64'(IMEM_ADDR), 64'h100);
            check("notready_stall", 64'(STALL_PC), 64'd1);
            step(1'b0);
        end
        IMEM_READY = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            RST        = ($urandom_range(0, 399) == 0);
            PC_VALID   = ($urandom_range(0, 7) != 0);
            IMEM_READY = ($urandom_range(0, 3) != 0);
            CLEAR      = ($urandom_range(0, 15) == 0);
            STALL      = ($urandom_range(0, 2) == 0);
            if (m_inflight.size() != 0) IMEM_RVALID = ($urandom_range(0, 2) != 0);
            else                        IMEM_RVALID = ($urandom_range(0, 9) == 0);
            IMEM_RDATA = $urandom;
            tick();
            if (m_last_clear)       PC = $urandom & 32'hFFFF_FFFC;
            else if (m_last_accept) PC = PC + 32'd4;
        end

        RST = 1'b0; CLEAR = 1'b0; IMEM_RVALID = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
